// File: rtl/life_row_scanner.sv
// Double-buffered 16x16 LED row scanner fed by the Life engine over valid/ready.
// Optional live-cell count of each displayed frame: define LIFE_POPCOUNT_EN.
module life_row_scanner #(
   parameter int ROW_HOLD = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         on,
   input  logic [255:0] frame_in,
   input  logic         frame_valid,
   output logic         frame_ready,
   output logic [15:0]  row_data,
   output logic [15:0]  row_sel,
   output logic [3:0]   row_idx,
   output logic         frame_start,
   output logic [8:0]   popcount,
   output logic         pop_valid
);
   typedef enum logic {IDLE, SCAN} state_t;
   localparam logic [15:0] HOLD_LAST = 16'(ROW_HOLD - 1);

   state_t        state, state_nxt;
   logic [255:0]  pending, active;
   logic          pending_full, loaded;
   logic [15:0]   hold, hold_nxt;
   logic [3:0]    row_cnt, row_cnt_nxt;
   logic          accept, swap, last_hold, show;

   assign accept    = frame_valid && frame_ready;
   assign last_hold = (hold == HOLD_LAST);
   assign show      = (state == SCAN) && on;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold;
      row_cnt_nxt = row_cnt;
      swap        = 1'b0;
      case (state)
         IDLE: begin
            swap        = pending_full;
            hold_nxt    = '0;
            row_cnt_nxt = '0;
            if (on && (loaded || pending_full)) state_nxt = SCAN;
         end
         SCAN: begin
            if (!on) begin
               state_nxt   = IDLE;
               hold_nxt    = '0;
               row_cnt_nxt = '0;
            end else if (last_hold) begin
               hold_nxt    = '0;
               row_cnt_nxt = row_cnt + 4'd1;
               swap        = pending_full && (row_cnt == 4'd15);
            end else begin
               hold_nxt    = hold + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hold    <= '0;
         row_cnt <= '0;
      end else begin
         state   <= state_nxt;
         hold    <= hold_nxt;
         row_cnt <= row_cnt_nxt;
      end
   end

   // NOTE: both frame buffers are cleared on reset so a discarded frame can never resurface.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending      <= '0;
         active       <= '0;
         pending_full <= 1'b0;
         loaded       <= 1'b0;
         frame_ready  <= 1'b1;
      end else begin
         if (accept) pending <= frame_in;
         if (swap) begin
            active <= pending;
            loaded <= 1'b1;
         end
         // accept and swap are exclusive: accept needs pending empty, swap needs it full
         if (accept) begin
            pending_full <= 1'b1;
            frame_ready  <= 1'b0;
         end else if (swap) begin
            pending_full <= 1'b0;
            frame_ready  <= 1'b1;
         end
      end
   end

   // Output stage reads the active buffer before the edge, so row 15 of the old frame is never torn.
   always_ff @(posedge clk) begin
      if (reset || !show) begin
         row_sel     <= '0;
         row_data    <= '0;
         row_idx     <= '0;
         frame_start <= 1'b0;
      end else begin
         row_sel     <= 16'd1 << row_cnt;
         row_data    <= active[{row_cnt, 4'b0000} +: 16];
         row_idx     <= row_cnt;
         frame_start <= (hold == 16'd0) && (row_cnt == 4'd0);
      end
   end

`ifdef LIFE_POPCOUNT_EN
   logic [8:0] pop_sum;

   always_comb begin
      pop_sum = '0;
      for (int i = 0; i < 256; i++) pop_sum = pop_sum + {8'd0, pending[i]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         popcount  <= '0;
         pop_valid <= 1'b0;
      end else begin
         pop_valid <= swap;
         if (swap) popcount <= pop_sum;
      end
   end
`else
   assign popcount  = '0;
   assign pop_valid = 1'b0;
`endif

endmodule

// File: tb/tb_life_row_scanner.sv
// Self-checking bench for life_row_scanner: directed scenarios plus a randomized run,
// all compared against a frame-position model of the display.
module tb_life_row_scanner;
   localparam int ROW_HOLD  = 4;
   localparam int FRAME_CYC = 16 * ROW_HOLD;
`ifdef LIFE_POPCOUNT_EN
   localparam logic [8:0] EXP_POP9   = 9'd9;
   localparam logic [8:0] EXP_POP256 = 9'd256;
   localparam logic       EXP_PV     = 1'b1;
`else
   localparam logic [8:0] EXP_POP9   = 9'd0;
   localparam logic [8:0] EXP_POP256 = 9'd0;
   localparam logic       EXP_PV     = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset, on, frame_valid;
   logic [255:0] frame_in;
   logic         frame_ready;
   logic [15:0]  row_data, row_sel;
   logic [3:0]   row_idx;
   logic         frame_start;
   logic [8:0]   popcount;
   logic         pop_valid;

   int checks = 0;
   int errors = 0;

   // Reference model: display position within a frame plus the two buffers.
   bit           m_scan = 1'b0;
   int           m_pos = 0;
   logic [255:0] m_act = '0, m_pend = '0;
   bit           m_loaded = 1'b0, m_full = 1'b0;
   logic [15:0]  e_sel = '0, e_data = '0;
   logic [3:0]   e_idx = '0;
   logic         e_fs = 1'b0, e_ready = 1'b1, e_pv = 1'b0;
   logic [8:0]   e_pop = '0;

   life_row_scanner #(.ROW_HOLD(ROW_HOLD)) dut (
      .clk(clk), .reset(reset), .on(on), .frame_in(frame_in),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .row_data(row_data), .row_sel(row_sel), .row_idx(row_idx),
      .frame_start(frame_start), .popcount(popcount), .pop_valid(pop_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int r;
      bit sw, acc;
      if (reset) begin
         m_scan = 0; m_pos = 0; m_act = '0; m_pend = '0; m_loaded = 0; m_full = 0;
         e_sel = '0; e_data = '0; e_idx = '0; e_fs = 0; e_ready = 1; e_pop = '0; e_pv = 0;
         return;
      end
      if (m_scan && on) begin
         r      = m_pos / ROW_HOLD;
         e_sel  = 16'd1 << r;
         e_data = m_act[16*r +: 16];
         e_idx  = 4'(r);
         e_fs   = (m_pos == 0);
      end else begin
         e_sel = '0; e_data = '0; e_idx = '0; e_fs = 0;
      end
      acc = frame_valid && !m_full;
      sw  = 0;
      if (!m_scan) begin
         sw = m_full;
         if (on && (m_loaded || m_full)) begin
            m_scan = 1;
            m_pos  = 0;
         end
      end else if (!on) begin
         m_scan = 0;
      end else if (m_pos == FRAME_CYC - 1) begin
         m_pos = 0;
         sw    = m_full;
      end else begin
         m_pos++;
      end
      e_pv = 0;
      if (sw) begin
`ifdef LIFE_POPCOUNT_EN
         e_pop = 9'($countones(m_pend));
         e_pv  = 1;
`endif
         m_act = m_pend; m_loaded = 1; m_full = 0;
      end
      if (acc) begin
         m_pend = frame_in;
         m_full = 1;
      end
      e_ready = !m_full;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("row_sel",     row_sel,     e_sel);
      check("row_data",    row_data,    e_data);
      check("row_idx",     row_idx,     e_idx);
      check("frame_start", frame_start, e_fs);
      check("frame_ready", frame_ready, e_ready);
      check("popcount",    popcount,    e_pop);
      check("pop_valid",   pop_valid,   e_pv);
   endtask

   task automatic wait_row(input logic [3:0] target, input int limit);
      for (int i = 0; i < limit && row_idx !== target; i++) tick();
      check("wait_row", row_idx, target);
   endtask

   task automatic wait_fs(input int limit);
      for (int i = 0; i < limit && frame_start !== 1'b1; i++) tick();
      check("wait_frame_start", frame_start, 1'b1);
   endtask

   function automatic logic [255:0] rand_frame();
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[32*i +: 32] = $urandom;
      return f;
   endfunction

   initial begin
      logic [255:0] f1, fb, fc, fp;
      int ready_hi;

      reset = 1'b1; on = 1'b0; frame_valid = 1'b0; frame_in = '0;
      repeat (3) tick();
      check("rst_ready",   frame_ready, 1'b1);
      check("rst_row_sel", row_sel,     16'h0000);
      check("rst_pop",     popcount,    9'd0);

      // Single frame, row r lights column r
      for (int r = 0; r < 16; r++) f1[16*r +: 16] = 16'h0001 << r;
      reset = 1'b0; on = 1'b1; frame_valid = 1'b1; frame_in = f1;
      tick();
      check("t1_ready_drop", frame_ready, 1'b0);
      frame_valid = 1'b0;
      tick();
      check("t1_ready_rise", frame_ready, 1'b1);
      check("t1_not_yet",    row_sel,     16'h0000);
      tick();
      check("t1_row0_sel",  row_sel,     16'h0001);
      check("t1_row0_data", row_data,    16'h0001);
      check("t1_row0_fs",   frame_start, 1'b1);
      repeat (60) tick();
      check("t1_row15_data", row_data, 16'h8000);
      check("t1_row15_sel",  row_sel,  16'h8000);
      check("t1_row15_idx",  row_idx,  4'd15);
      repeat (4) tick();
      check("t1_wrap_fs",   frame_start, 1'b1);
      check("t1_wrap_data", row_data,    16'h0001);

      // Blank mid-scan at row 7, then restart from row 0 with the same frame
      wait_row(4'd7, 80);
      on = 1'b0;
      tick();
      check("t3_blank_sel",  row_sel,  16'h0000);
      check("t3_blank_data", row_data, 16'h0000);
      on = 1'b1;
      tick();
      check("t3_restart_gap", row_sel, 16'h0000);
      tick();
      check("t3_restart_sel",  row_sel,     16'h0001);
      check("t3_restart_fs",   frame_start, 1'b1);
      check("t3_restart_data", row_data,    16'h0001);

      // Back-pressure: B waits for the row-15 wrap, C stalls until then
      fb = rand_frame();
      fc = rand_frame();
      frame_valid = 1'b1; frame_in = fb;
      tick();
      check("t2_b_accept", frame_ready, 1'b0);
      frame_in = fc;
      ready_hi = 0;
      for (int i = 0; i < 80 && frame_start !== 1'b1; i++) begin
         tick();
         if (frame_ready === 1'b1) ready_hi++;
      end
      check("t2_wrap_fs",      frame_start, 1'b1);
      check("t2_b_row0",       row_data,    fb[15:0]);
      check("t2_c_taken",      frame_ready, 1'b0);
      check("t2_ready_window", ready_hi,    1);
      frame_valid = 1'b0;
      wait_row(4'd1, 20);
      check("t2_b_row1", row_data, fb[31:16]);

      // Reset at row 9 with C pending discards everything
      wait_row(4'd9, 80);
      reset = 1'b1;
      tick();
      check("t4_sel",   row_sel,     16'h0000);
      check("t4_data",  row_data,    16'h0000);
      check("t4_idx",   row_idx,     4'd0);
      check("t4_fs",    frame_start, 1'b0);
      check("t4_ready", frame_ready, 1'b1);
      reset = 1'b0;
      repeat (10) tick();
      check("t4_no_scan", row_sel, 16'h0000);

      // Live-cell count
      fp = 256'h0000200020002000000020002000200000000000000000000010001000100000;
      frame_valid = 1'b1; frame_in = fp;
      tick();
      frame_valid = 1'b0;
      tick();
      check("t5_pv_pulse", pop_valid, EXP_PV);
      check("t5_pop9",     popcount,  EXP_POP9);
      tick();
      check("t5_pv_low", pop_valid,   1'b0);
      check("t5_fs",     frame_start, 1'b1);
      frame_valid = 1'b1; frame_in = '1;
      tick();
      frame_valid = 1'b0;
      wait_fs(80);
      check("t5_pop256", popcount, EXP_POP256);
      check("t5_ones",   row_data, 16'hffff);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int pick;
         on          = ($urandom_range(0, 15) != 0);
         frame_valid = ($urandom_range(0, 3) == 0);
         reset       = ($urandom_range(0, 499) == 0);
         pick        = $urandom_range(0, 7);
         frame_in    = (pick == 0) ? '0 : (pick == 1) ? '1 : rand_frame();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
